// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter and branch-redirect stage.
// Holds the architectural PC, issues fetch requests to instruction memory and
// redirects on taken branches (target = branch_pc4 + branch_off_sl2).
// Optional J-type redirect is compiled in when PC_BRANCH_JUMP_EN is defined.
//
// Fetch handshake: pc is a request whenever pc_valid is high; it is accepted
// on a rising edge where pc_valid & pc_ready & !stall, and the PC then moves
// to pc + 4. While pc_valid & !pc_ready the request (pc) is held stable,
// unless a redirect replaces it.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        pc_ready,
  input  logic        branch_valid,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc4,
  input  logic [31:0] branch_off_sl2,
`ifdef PC_BRANCH_JUMP_EN
  input  logic        jump_valid,
  input  logic [25:0] jump_index,
`endif
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic        flush_nxt;
  logic        valid_nxt;

  logic [31:0] branch_target;
  logic        take_branch;
  logic [31:0] jump_target;
  logic        take_jump;
  logic        redirect;

  // Redirect targets are pure combinational functions of the inputs.
  assign take_branch   = branch_valid & branch_taken;
  assign branch_target = (branch_pc4 + branch_off_sl2) & 32'hFFFF_FFFC;

`ifdef PC_BRANCH_JUMP_EN
  assign take_jump   = jump_valid;
  assign jump_target = {branch_pc4[31:28], jump_index, 2'b00};
`else
  assign take_jump   = 1'b0;
  assign jump_target = 32'h0000_0000;
`endif

  assign redirect  = take_branch | take_jump;
  assign dbg_state = state;

  // State and output registers; reset wins over any pending redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      pc_valid <= 1'b0;
      flush    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pc_valid <= valid_nxt;
      flush    <= flush_nxt;
    end
  end

  // Next-state: BOOT always moves on; a redirect parks in REDIRECT for a cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:           state_nxt = FETCH;
      FETCH, REDIRECT: state_nxt = redirect ? REDIRECT : FETCH;
      default:        state_nxt = BOOT;
    endcase
  end

  // Next register values: redirect beats stall, stall beats acceptance.
  always_comb begin
    pc_nxt    = pc;
    flush_nxt = 1'b0;
    valid_nxt = 1'b1;
    case (state)
      FETCH, REDIRECT: begin
        if (take_branch) begin
          pc_nxt    = branch_target;
          flush_nxt = 1'b1;
        end else if (take_jump) begin
          pc_nxt    = jump_target;
          flush_nxt = 1'b1;
        end else if (!stall && pc_ready) begin
          pc_nxt = pc + 32'd4;
        end
      end
      default: begin
        pc_nxt    = pc;
        flush_nxt = 1'b0;
        valid_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed bench for pc_branch_unit with a behavioural
// reference model compared every cycle, plus literal checks at key points.
// Build with PC_BRANCH_JUMP_EN defined to include the J-type cases.
module tb_pc_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        pc_ready;
  logic        branch_valid;
  logic        branch_taken;
  logic [31:0] branch_pc4;
  logic [31:0] branch_off_sl2;
`ifdef PC_BRANCH_JUMP_EN
  logic        jump_valid;
  logic [25:0] jump_index;
`endif
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  pc_branch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .pc_ready       (pc_ready),
    .branch_valid   (branch_valid),
    .branch_taken   (branch_taken),
    .branch_pc4     (branch_pc4),
    .branch_off_sl2 (branch_off_sl2),
`ifdef PC_BRANCH_JUMP_EN
    .jump_valid     (jump_valid),
    .jump_index     (jump_index),
`endif
    .pc             (pc),
    .pc_valid       (pc_valid),
    .flush          (flush),
    .dbg_state      (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch stage must show after each edge.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_flush;
  bit          m_known = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_valid = 1'b0; m_flush = 1'b0; m_known = 1;
    end else if (m_known) begin
      if (!m_valid) begin
        m_valid = 1'b1; m_flush = 1'b0;
      end else if (branch_valid && branch_taken) begin
        m_pc = (branch_pc4 + branch_off_sl2) & ~32'h3;
        m_flush = 1'b1;
`ifdef PC_BRANCH_JUMP_EN
      end else if (jump_valid) begin
        m_pc = (branch_pc4 & 32'hF000_0000) | (32'(jump_index) << 2);
        m_flush = 1'b1;
`endif
      end else begin
        if (!stall && pc_ready) m_pc = m_pc + 32'd4;
        m_flush = 1'b0;
      end
    end
  end

  // Compare process on the falling edge.
  always @(negedge clk) begin
    if (m_known) begin
      check("model_pc", pc, m_pc);
      check("model_pc_valid", {31'b0, pc_valid}, {31'b0, m_valid});
      check("model_flush", {31'b0, flush}, {31'b0, m_flush});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_branch(input logic v, input logic t, input logic [31:0] p4, input logic [31:0] off);
    branch_valid = v; branch_taken = t; branch_pc4 = p4; branch_off_sl2 = off;
  endtask

  task automatic expect_out(input string name, input logic [31:0] e_pc, input logic e_v, input logic e_f);
    check({name, "_pc"}, pc, e_pc);
    check({name, "_valid"}, {31'b0, pc_valid}, {31'b0, e_v});
    check({name, "_flush"}, {31'b0, flush}, {31'b0, e_f});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; pc_ready = 1'b0;
    set_branch(1'b0, 1'b0, 32'h0, 32'h0);
`ifdef PC_BRANCH_JUMP_EN
    jump_valid = 1'b0; jump_index = 26'h0;
`endif
    #1;
    step(); step();
    expect_out("reset", 32'h0, 1'b0, 1'b0);
    pc_ready = 1'b1; rst_n = 1'b1;
    #2;
    expect_out("boot", 32'h0, 1'b0, 1'b0);
    step(); expect_out("seq0", 32'h0, 1'b1, 1'b0);
    step(); expect_out("seq1", 32'h4, 1'b1, 1'b0);
    step(); expect_out("seq2", 32'h8, 1'b1, 1'b0);
    step(); expect_out("seq3", 32'hC, 1'b1, 1'b0);

    // Taken branch
    set_branch(1'b1, 1'b1, 32'h0000_0010, 32'h8D17_C000);
    step(); expect_out("br_taken", 32'h8D17_C010, 1'b1, 1'b1);
    set_branch(1'b0, 1'b0, 32'h0, 32'h0);
    step(); expect_out("br_after", 32'h8D17_C014, 1'b1, 1'b0);

    // Wrap-around target and not-taken
    set_branch(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h8);
    step(); expect_out("br_wrap", 32'h0000_0004, 1'b1, 1'b1);
    set_branch(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h8);
    step(); expect_out("br_not_taken", 32'h0000_0008, 1'b1, 1'b0);
    step(); expect_out("br_not_taken2", 32'h0000_000C, 1'b1, 1'b0);
    set_branch(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    expect_out("at_20", 32'h20, 1'b1, 1'b0);

    // Stall and handshake hold
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("stall_hold", 32'h20, 1'b1, 1'b0);
    end
    stall = 1'b0; pc_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(); expect_out("not_ready_hold", 32'h20, 1'b1, 1'b0);
    end
    stall = 1'b1; pc_ready = 1'b1;
    set_branch(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0040);
    step(); expect_out("stall_redirect", 32'h140, 1'b1, 1'b1);
    set_branch(1'b0, 1'b0, 32'h0, 32'h0);
    step(); expect_out("stall_after_redir", 32'h140, 1'b1, 1'b0);
    stall = 1'b0;
    step(); expect_out("resume", 32'h144, 1'b1, 1'b0);

    // Back-to-back taken branches, last wins; unaligned pc4 is masked
    set_branch(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0010);
    step(); expect_out("b2b_1", 32'h210, 1'b1, 1'b1);
    set_branch(1'b1, 1'b1, 32'h0000_0300, 32'hFFFF_FFFC);
    step(); expect_out("b2b_2", 32'h2FC, 1'b1, 1'b1);
    set_branch(1'b1, 1'b1, 32'h0000_1001, 32'h0000_0004);
    step(); expect_out("b2b_mask", 32'h1004, 1'b1, 1'b1);
    set_branch(1'b0, 1'b0, 32'h0, 32'h0);
    step(); expect_out("b2b_after", 32'h1008, 1'b1, 1'b0);

`ifdef PC_BRANCH_JUMP_EN
    // Jump redirect and branch-over-jump priority
    jump_valid = 1'b1; jump_index = 26'h012_3456;
    set_branch(1'b0, 1'b0, 32'h1000_0004, 32'h0);
    step(); expect_out("jump", 32'h1048_D158, 1'b1, 1'b1);
    set_branch(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0020);
    step(); expect_out("jump_vs_branch", 32'h60, 1'b1, 1'b1);
    jump_valid = 1'b0;
    set_branch(1'b0, 1'b0, 32'h0, 32'h0);
    step(); expect_out("jump_after", 32'h64, 1'b1, 1'b0);
`endif

    // Reset on the same edge as a taken branch
    set_branch(1'b1, 1'b1, 32'h0000_4000, 32'h0000_0100);
    rst_n = 1'b0;
    step(); expect_out("mid_reset", 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    set_branch(1'b0, 1'b0, 32'h0, 32'h0);
    step(); expect_out("post_reset0", 32'h0, 1'b1, 1'b0);
    step(); expect_out("post_reset1", 32'h4, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
